// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: default sizes and the
// helper that sizes requester index/pointer fields.
package rr_mux_arbiter_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 8;

    // $clog2(1) and $clog2(2) differ, but an index field is always at least 1 bit wide.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef logic [clog2_min1(DEFAULT_N_REQ)-1:0] default_idx_t;

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin search: the first set request at or after ptr_i,
// otherwise the lowest set request (wrap-around).
module rr_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int IDX_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] winner_o
);

    typedef logic [IDX_W-1:0] idx_t;

    logic hi_found;
    idx_t hi_idx;
    idx_t lo_idx;

    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path leaves it unassigned (no latch).
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        // Descending scan so the lowest qualifying index is the last one written.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_idx = idx_t'(i);
                if (idx_t'(i) >= ptr_i) begin
                    hi_found = 1'b1;
                    hi_idx   = idx_t'(i);
                end
            end
        end
        any_o    = |req_i;
        winner_o = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin N_REQ:1 valid/ready arbiter with a registered output beat.
// Define RR_MUX_ARBITER_PACKET_LOCK_EN to add in_last/out_last and packet locking.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         in_valid,
    input  logic [N_REQ*WIDTH-1:0]   in_data,
    output logic [N_REQ-1:0]         in_ready,
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    input  logic [N_REQ-1:0]         in_last,
    output logic                     out_last,
`endif
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(N_REQ)-1:0] out_src,
    input  logic                     out_ready
);

    localparam int IDX_W = clog2_min1(N_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    idx_t             ptr_q;
    idx_t             ptr_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    idx_t             out_src_q;

    logic             pick_any;
    idx_t             pick_winner;
    logic             any;
    idx_t             winner;
    logic             can_load;
    logic             accept;
    logic [WIDTH-1:0] sel_data;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i    (in_valid),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .winner_o (pick_winner)
    );

`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    logic locked_q;
    idx_t lock_src_q;
    logic out_last_q;
    logic sel_last;

    // A locked packet forces the winner and bypasses the round-robin search.
    always_comb begin
        if (locked_q) begin
            any    = in_valid[lock_src_q];
            winner = lock_src_q;
        end else begin
            any    = pick_any;
            winner = pick_winner;
        end
    end

    assign sel_last = in_last[winner];
    assign out_last = out_last_q;
`else
    assign any    = pick_any;
    assign winner = pick_winner;
`endif

    assign can_load = !out_valid_q || out_ready;
    // Reset also masks the handshake so no requester sees a grant while rst is high.
    assign accept   = !rst && can_load && any;
    assign ptr_d    = (winner == idx_t'(N_REQ - 1)) ? '0 : winner + idx_t'(1);

    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == idx_t'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
            locked_q    <= 1'b0;
            lock_src_q  <= '0;
            out_last_q  <= 1'b0;
`endif
        end else if (can_load) begin
            if (any) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_src_q   <= winner;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
                out_last_q  <= sel_last;
                locked_q    <= !sel_last;
                lock_src_q  <= winner;
                if (sel_last) begin
                    ptr_q <= ptr_d;
                end
`else
                ptr_q       <= ptr_d;
`endif
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a driver predicts grants from a
// round-robin reference and queues expected beats; a monitor checks the output.
module tb_rr_mux_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready = 1'b0;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    logic [N-1:0]   in_last = '1;
    logic           out_last;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] data;
        int           src;
    } beat_t;

    beat_t sb[$];
    int    m_ptr   = 0;
    bit    m_valid = 1'b0;
    bit    mon_en  = 1'b0;

    rr_mux_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: first valid requester scanning ptr, ptr+1, ... modulo N.
    function automatic int rr_pick_ref(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
        bit           can_load;
        int           w;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #2;
        can_load = !m_valid || r;
        w        = rr_pick_ref(v, m_ptr);
        exp_rdy  = '0;
        if (can_load && w >= 0) begin
            exp_rdy[w] = 1'b1;
            sb.push_back('{d[w*W +: W], w});
            m_valid = 1'b1;
            m_ptr   = (w + 1) % N;
        end else if (can_load) begin
            m_valid = 1'b0;
        end
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
    endtask

    task automatic do_reset(input int cycles);
        mon_en = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = '1;
        out_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            #2;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
        end
        sb.delete();
        m_ptr   = 0;
        m_valid = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = '0;
        mon_en   = 1'b1;
    endtask

    // Monitor: output must match the head of the scoreboard every cycle it is valid.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("out_valid", 32'(out_valid), 32'(sb.size() > 0));
                if (out_valid && sb.size() > 0) begin
                    check("out_data", 32'(out_data), 32'(sb[0].data));
                    check("out_src", 32'(out_src), 32'(sb[0].src));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [N*W-1:0] d_a;
        d_a = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        do_reset(2);
        repeat (8) drive('1, d_a, 1'b1);

        do_reset(1);
        repeat (4) drive(4'b1010, d_a, 1'b1);
        drive(4'b0001, d_a, 1'b1);

        drive(4'b0001, {24'h0, 8'h55}, 1'b1);
        repeat (3) drive('1, d_a, 1'b0);
        drive('1, d_a, 1'b1);

        repeat (2) drive('0, d_a, 1'b1);
        repeat (3) drive('1, d_a, 1'b1);

        for (int k = 0; k < 400; k++) begin
            if (k % 150 == 149) do_reset(1);
            drive(N'($urandom), $urandom, ($urandom_range(0, 3) != 0));
        end

        repeat (3) drive('0, '0, 1'b1);
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one registered output channel between N_REQ valid/ready requesters.
- Selects one requester per cycle through an N_REQ:1 data mux, registers the winning beat, and advances a rotating priority pointer.
- Sits in front of any single-consumer datapath that several producers must share.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8, not required to be a power of two.
- WIDTH, 8, data width per requester in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N_REQ  per-requester valid; bit i belongs to requester i.
- in_data  input  N_REQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N_REQ  per-requester accept, combinational; at most one bit set.
- out_valid  output  1  registered output beat valid.
- out_data  output  WIDTH  registered output data.
- out_src  output  $clog2(N_REQ)  index of the requester that produced the current out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset: out_valid=0, out_data=0, out_src=0, ptr=0. in_ready is all-zero whenever out_valid=1 and out_ready=0.
- can_load = !out_valid || out_ready.
- Winner: first i with in_valid[i]=1, searching ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
- in_ready[winner] = can_load && |in_valid. All other in_ready bits are 0.
- Transfer: requester i's beat is accepted in a cycle where in_valid[i] && in_ready[i].
- On accept: out_data <= in_data[winner], out_src <= winner, out_valid <= 1.
- Pointer update on accept: ptr <= winner+1, wrapping to 0 after N_REQ-1.
- can_load=1 and no in_valid: out_valid <= 0. ptr and out_data hold.
- out_valid=1 and out_ready=0: out_valid, out_data and out_src hold stable. ptr holds, no input is accepted.
- Latency: accepted beat appears on the output exactly 1 cycle later.
- Throughput: 1 beat/cycle when out_ready is held high.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0,… and each requester waits at most N_REQ-1 grants.
- Simultaneous out_ready and a new accept: the old beat is consumed and the new beat loads in the same edge (no bubble).
- in_valid may deassert before acceptance without protocol error. The arbiter re-evaluates every cycle and never latches a request.
- Reset mid-operation: any held beat is dropped and ptr returns to 0. rst has priority over every other event.
- N_REQ not a power of two: ptr must never take a value ≥ N_REQ.

Optional Feature:
- Macro: RR_MUX_ARBITER_PACKET_LOCK_EN.
- With the macro: adds input in_last[N_REQ] and output out_last (registered alongside out_data, reset 0).
  - After accepting a beat with in_last=0 from requester i, the arbiter locks to i.
  - While locked, only requester i can be granted, whatever ptr is, and ptr does not advance.
  - The lock releases on acceptance of i's beat with in_last=1; ptr then becomes i+1.
  - Reset clears the lock.
- Without the macro: no in_last/out_last ports and no lock state; every beat is arbitrated independently.

Decomposition:
- Package rr_mux_arbiter_pkg:
  - function clog2_min1(n), returning max(1,$clog2(n)) for index widths;
  - localparam default widths;
  - typedef for the pointer/index type, parameterised by the width function.
- Sub-module rr_pick: purely combinational.
  - Inputs: req vector and ptr.
  - Outputs: any and winner index.
  - Implemented as a rotate/search with wrap.
  - Reused by the lock path (forced winner bypasses it).

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=4'b1111 → out_valid=0, in_ready=0 during reset; after release the first grant goes to requester 0.
- All four valid continuously, out_ready=1, in_data[i]=8'hA0+i → out_data sequence A0,A1,A2,A3,A0,…, one per cycle; out_src=0,1,2,3,0.
- in_valid=4'b1010 with ptr=0 → grants 1,3,1,3; then in_valid=4'b0001 after requester 3's grant → requester 0 is granted next (wrap).
- Backpressure: out_ready=0 for 3 cycles while holding beat 8'h55 → out_data=55, out_valid=1 stable, in_ready=0; out_ready=1 then loads the next beat on the same edge.
- Idle: all in_valid=0 with out_ready=1 → out_valid drops to 0 the next cycle; ptr unchanged (verified by the next grant order).
- With RR_MUX_ARBITER_PACKET_LOCK_EN: requester 2 sends 3 beats (last on the 3rd) while requesters 0, 1 and 3 are valid → output shows src 2,2,2, then 3,0,1.
